// File: rtl/vga_pkg.sv
//------------------------------------------------------------------------------
// Module : vga_pkg
// Brief  : Shared 640x480 timing constants, coordinate width and the sprite
//          motion FSM state encoding.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package vga_pkg;

  // Width of every pixel / line coordinate on the video path
  localparam int COORD_W = 11;

  // Visible area of the 640x480@60 mode
  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_V_ACTIVE = 480;

  // Motion FSM encoding
  localparam int ST_W = 2;
  typedef logic [ST_W-1:0] state_t;
  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_CALC   = 2'd1;
  localparam state_t ST_COMMIT = 2'd2;

endpackage : vga_pkg

`default_nettype wire

// File: rtl/sprite_axis_bounce.sv
//------------------------------------------------------------------------------
// Module : sprite_axis_bounce
// Brief  : One axis of the bouncing-sprite motion. Computes the next position
//          and direction for a single step, clamping at 0 and LIMIT and
//          flagging a reflection. Results are registered on calc_en_i.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module sprite_axis_bounce
  import vga_pkg::*;
#(
  parameter int LIMIT = 296,  // largest legal top-left coordinate
  parameter int STEP  = 2     // movement per update
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [COORD_W-1:0] pos_i,
  input  logic               dir_i,       // 1 = increasing, 0 = decreasing
  input  logic               calc_en_i,
  output logic [COORD_W-1:0] next_pos_o,
  output logic               next_dir_o,
  output logic               flipped_o
);

  // One extra bit so the compares can never wrap
  localparam logic [COORD_W:0]   c_STEP_W   = (COORD_W+1)'(STEP);
  localparam logic [COORD_W:0]   c_LIMIT_W  = (COORD_W+1)'(LIMIT);
  localparam logic [COORD_W-1:0] c_STEP     = COORD_W'(STEP);
  localparam logic [COORD_W-1:0] c_LIMIT    = COORD_W'(LIMIT);

  logic [COORD_W:0]   w_sum_wide;
  logic [COORD_W-1:0] w_pos_d;
  logic               w_dir_d;
  logic               w_flip_d;

  logic [COORD_W-1:0] next_pos_q;
  logic               next_dir_q;
  logic               flipped_q;

  assign w_sum_wide = {1'b0, pos_i} + c_STEP_W;

  // Reflection rule: clamp to the edge and reverse when the step would reach it
  always_comb begin
    w_pos_d  = pos_i;
    w_dir_d  = dir_i;
    w_flip_d = 1'b0;
    if (dir_i) begin
      if (w_sum_wide >= c_LIMIT_W) begin
        w_pos_d  = c_LIMIT;
        w_dir_d  = 1'b0;
        w_flip_d = 1'b1;
      end else begin
        w_pos_d  = pos_i + c_STEP;
      end
    end else begin
      if ({1'b0, pos_i} <= c_STEP_W) begin
        w_pos_d  = '0;
        w_dir_d  = 1'b1;
        w_flip_d = 1'b1;
      end else begin
        w_pos_d  = pos_i - c_STEP;
      end
    end
  end

  // Capture the computed step only in the CALC cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      next_pos_q <= '0;
      next_dir_q <= 1'b1;
      flipped_q  <= 1'b0;
    end else if (calc_en_i) begin
      next_pos_q <= w_pos_d;
      next_dir_q <= w_dir_d;
      flipped_q  <= w_flip_d;
    end
  end

  assign next_pos_o = next_pos_q;
  assign next_dir_o = next_dir_q;
  assign flipped_o  = flipped_q;

endmodule : sprite_axis_bounce

`default_nettype wire

// File: rtl/sprite_motion_ctrl.sv
//------------------------------------------------------------------------------
// Module : sprite_motion_ctrl
// Brief  : Bouncing-sprite bounding-box generator. Detects the start of
//          vertical blank, then runs IDLE->CALC->COMMIT once per frame (run
//          mode, divided by FRAME_DIV) or once per step request (paused).
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module sprite_motion_ctrl
  import vga_pkg::*;
#(
  parameter int H_ACTIVE  = VGA_H_ACTIVE,
  parameter int V_ACTIVE  = VGA_V_ACTIVE,
  parameter int SPR_W     = 344,
  parameter int SPR_H     = 48,
  parameter int X_INIT    = 100,
  parameter int Y_INIT    = 100,
  parameter int STEP_X    = 2,
  parameter int STEP_Y    = 1,
  parameter int FRAME_DIV = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [COORD_W-1:0] hcount_i,
  input  logic [COORD_W-1:0] vcount_i,
  input  logic               run_i,
  input  logic               step_i,
  output logic [COORD_W-1:0] x0_o,
  output logic [COORD_W-1:0] y0_o,
  output logic [COORD_W-1:0] x1_o,
  output logic [COORD_W-1:0] y1_o,
  output logic               frame_tick_o,
  output logic               bounce_o,
  output logic [7:0]         bounce_cnt_o
);

  localparam int DIV_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;

  localparam logic [DIV_W-1:0]   c_DIV_LAST = DIV_W'(FRAME_DIV - 1);
  localparam logic [COORD_W-1:0] c_V_TICK   = COORD_W'(V_ACTIVE);
  localparam logic [COORD_W-1:0] c_X_INIT   = COORD_W'(X_INIT);
  localparam logic [COORD_W-1:0] c_Y_INIT   = COORD_W'(Y_INIT);
  localparam logic [COORD_W-1:0] c_W_M1     = COORD_W'(SPR_W - 1);
  localparam logic [COORD_W-1:0] c_H_M1     = COORD_W'(SPR_H - 1);

  state_t             state_q, state_d;
  logic               frame_tick_q;
  logic [DIV_W-1:0]   div_q, div_d;
  logic               step_pend_q, step_pend_d;
  logic [COORD_W-1:0] x0_q, y0_q, x1_q, y1_q;
  logic               dir_x_q, dir_y_q;
  logic               bounce_q;
  logic [7:0]         bounce_cnt_q;

  logic               w_div_req;
  logic               w_calc_en;
  logic               w_commit_en;
  logic [COORD_W-1:0] w_nx, w_ny;
  logic               w_ndir_x, w_ndir_y;
  logic               w_flip_x, w_flip_y;

  // Pulse once per frame on the first pixel of the first blanking line
  always_ff @(posedge clk) begin
    if (rst) frame_tick_q <= 1'b0;
    else     frame_tick_q <= (hcount_i == '0) && (vcount_i == c_V_TICK);
  end

  assign w_div_req = frame_tick_q && run_i && (div_q == c_DIV_LAST);

  // Frame divider advances only on ticks while running and holds when paused
  always_comb begin
    div_d = div_q;
    if (frame_tick_q && run_i) begin
      div_d = (div_q == c_DIV_LAST) ? '0 : div_q + DIV_W'(1);
    end
  end

  // A paused step is latched until consumed; extra pulses merge into one
  always_comb begin
    step_pend_d = step_pend_q;
    if (w_commit_en)          step_pend_d = 1'b0;
    else if (step_i && !run_i) step_pend_d = 1'b1;
  end

  // FSM state register plus divider and step bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      div_q       <= '0;
      step_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      step_pend_q <= step_pend_d;
    end
  end

  // FSM next state: start an update only on a frame tick with a request
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (frame_tick_q && (w_div_req || step_pend_q)) state_d = ST_CALC;
      ST_CALC:   state_d = ST_COMMIT;
      ST_COMMIT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: compute strobe and load strobe
  always_comb begin
    w_calc_en   = 1'b0;
    w_commit_en = 1'b0;
    case (state_q)
      ST_CALC:   w_calc_en   = 1'b1;
      ST_COMMIT: w_commit_en = 1'b1;
      default:   ;
    endcase
  end

  sprite_axis_bounce #(
    .LIMIT (H_ACTIVE - SPR_W),
    .STEP  (STEP_X)
  ) u_axis_x (
    .clk        (clk),
    .rst        (rst),
    .pos_i      (x0_q),
    .dir_i      (dir_x_q),
    .calc_en_i  (w_calc_en),
    .next_pos_o (w_nx),
    .next_dir_o (w_ndir_x),
    .flipped_o  (w_flip_x)
  );

  sprite_axis_bounce #(
    .LIMIT (V_ACTIVE - SPR_H),
    .STEP  (STEP_Y)
  ) u_axis_y (
    .clk        (clk),
    .rst        (rst),
    .pos_i      (y0_q),
    .dir_i      (dir_y_q),
    .calc_en_i  (w_calc_en),
    .next_pos_o (w_ny),
    .next_dir_o (w_ndir_y),
    .flipped_o  (w_flip_y)
  );

  // Bounding box, directions and bounce statistics change only on COMMIT
  always_ff @(posedge clk) begin
    if (rst) begin
      x0_q         <= c_X_INIT;
      y0_q         <= c_Y_INIT;
      x1_q         <= c_X_INIT + c_W_M1;
      y1_q         <= c_Y_INIT + c_H_M1;
      dir_x_q      <= 1'b1;
      dir_y_q      <= 1'b1;
      bounce_q     <= 1'b0;
      bounce_cnt_q <= '0;
    end else begin
      bounce_q <= 1'b0;
      if (w_commit_en) begin
        x0_q    <= w_nx;
        y0_q    <= w_ny;
        x1_q    <= w_nx + c_W_M1;
        y1_q    <= w_ny + c_H_M1;
        dir_x_q <= w_ndir_x;
        dir_y_q <= w_ndir_y;
        if (w_flip_x || w_flip_y) begin
          bounce_q     <= 1'b1;
          bounce_cnt_q <= bounce_cnt_q + 8'd1;
        end
      end
    end
  end

  assign x0_o         = x0_q;
  assign y0_o         = y0_q;
  assign x1_o         = x1_q;
  assign y1_o         = y1_q;
  assign frame_tick_o = frame_tick_q;
  assign bounce_o     = bounce_q;
  assign bounce_cnt_o = bounce_cnt_q;

endmodule : sprite_motion_ctrl

`default_nettype wire
